// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin arbiter that funnels NUM_REQ producers into one
// downstream FIFO push port, with a flush handshake (IDLE -> FLUSH -> ACK).
// Grants are combinational from req_i; the pointer and FSM are registered.
// Optional feature: define FIFO_PUSH_ARB_STATS_EN to add stall_cnt_o, a
// saturating 16-bit count of cycles where some producer waits without a grant.
module fifo_push_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  input  logic                                 flush_req_i,
  output logic                                 flush_ack_o,
  input  logic                                 fifo_full_i,
  output logic                                 fifo_push_o,
  output logic [DATA_WIDTH-1:0]                fifo_data_o,
  output logic                                 fifo_flush_o,
  output logic [$clog2(NUM_REQ)-1:0]           idx_o
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output logic [15:0]                          stall_cnt_o
`endif
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]  NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic               arb_en_s;
  logic               found_s;
  logic [IDX_W:0]     cand_s;
  logic [IDX_W:0]     rr_inc_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   idx_s;
  logic               push_s;

  // Grants only in IDLE, with room downstream, no flush being requested and
  // reset released; a flush request wins over a simultaneous push.
  assign arb_en_s = rst_ni & (state_q == ST_IDLE) & ~flush_req_i & ~fifo_full_i;

  // Round-robin search: first requester at or after rr_q, wrapping at NUM_REQ.
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand_s >= NUM_REQ_L) begin
        cand_s = cand_s - NUM_REQ_L;
      end else begin
        cand_s = cand_s;
      end
      if (arb_en_s && !found_s && req_i[cand_s[IDX_W-1:0]]) begin
        found_s                    = 1'b1;
        gnt_s[cand_s[IDX_W-1:0]]   = 1'b1;
        idx_s                      = cand_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign push_s       = |(req_i & gnt_s);
  assign gnt_o        = gnt_s;
  assign idx_o        = idx_s;
  assign fifo_push_o  = push_s;
  assign fifo_data_o  = data_i[idx_s];
  assign fifo_flush_o = (state_q == ST_FLUSH);
  assign flush_ack_o  = (state_q == ST_ACK);

  // Next pointer: one past the pushed producer, zeroed by a flush, else hold.
  always_comb begin
    rr_d     = rr_q;
    rr_inc_s = {1'b0, idx_s} + {{IDX_W{1'b0}}, 1'b1};
    if (state_q == ST_FLUSH) begin
      rr_d = '0;
    end else if (push_s) begin
      if (rr_inc_s >= NUM_REQ_L) begin
        rr_d = '0;
      end else begin
        rr_d = rr_inc_s[IDX_W-1:0];
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Flush handshake: one FLUSH cycle, one ACK cycle; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and round-robin pointer registers; reset aborts any flush in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: counts waiting-but-ungranted cycles, saturates, cleared by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_FLUSH) begin
      stall_cnt_d = 16'h0000;
    end else if ((|req_i) && !push_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: a reference model predicts each
// cycle's grant; predicted pushes go into a scoreboard queue and are popped
// when the DUT strobes fifo_push_o.
module tb_fifo_push_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          req_i;
  logic [N-1:0][DW-1:0]  data_i;
  logic [N-1:0]          gnt_o;
  logic                  flush_req_i;
  logic                  flush_ack_o;
  logic                  fifo_full_i;
  logic                  fifo_push_o;
  logic [DW-1:0]         fifo_data_o;
  logic                  fifo_flush_o;
  logic [IW-1:0]         idx_o;
`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [15:0]           stall_cnt_o;
`endif

  fifo_push_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .data_i       (data_i),
    .gnt_o        (gnt_o),
    .flush_req_i  (flush_req_i),
    .flush_ack_o  (flush_ack_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_flush_o (fifo_flush_o),
    .idx_o        (idx_o)
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;

  // reference model: 0 IDLE, 1 FLUSH, 2 ACK
  int           m_state;
  logic [IW-1:0] m_rr;
  logic [15:0]  m_stall;
  logic [N-1:0] pend;
  logic [N-1:0] last_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rr    = '0;
    m_stall = 16'h0000;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs just after negedge, check outputs, advance model at posedge.
  task automatic step(input logic [N-1:0] req, input logic full, input logic flush);
    logic [N-1:0]  eg;
    logic [IW-1:0] ei;
    logic          found;
    int            c;
    exp_t          e;
    req_i       = req;
    fifo_full_i = full;
    flush_req_i = flush;
    #1;
    eg = '0;
    ei = '0;
    found = 1'b0;
    if (m_state == 0 && !flush && !full) begin
      for (int k = 0; k < N; k++) begin
        c = (int'(m_rr) + k) % N;
        if (!found && req[c]) begin
          found = 1'b1;
          eg[c] = 1'b1;
          ei    = c[IW-1:0];
        end
      end
    end
    if (found) begin
      e.idx  = ei;
      e.data = data_i[ei];
      sb_q.push_back(e);
    end
    check("gnt", gnt_o, eg);
    check("flush_o", fifo_flush_o, m_state == 1);
    check("ack_o", flush_ack_o, m_state == 2);
    if (!found) check("idx_none", idx_o, 0);
`ifdef FIFO_PUSH_ARB_STATS_EN
    check("stall_cnt", stall_cnt_o, m_stall);
`endif
    check("push", fifo_push_o, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (fifo_push_o) begin
        check("push_idx", idx_o, e.idx);
        check("push_data", fifo_data_o, e.data);
      end
    end
    last_gnt = eg;
    @(posedge clk_i);
    if (m_state == 1) m_stall = 16'h0000;
    else if ((|req) && !found && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
    if (m_state == 1) m_rr = '0;
    else if (found) m_rr = IW'((int'(ei) + 1) % N);
    case (m_state)
      0:       m_state = flush ? 1 : 0;
      1:       m_state = 2;
      default: m_state = 0;
    endcase
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_i       = 4'b1111;
    flush_req_i = 1'b0;
    fifo_full_i = 1'b0;
    pend        = '0;
    last_gnt    = '0;
    for (int k = 0; k < N; k++) data_i[k] = 32'hA000_0000 + 32'(k);
    model_reset();

    // reset state with all producers requesting
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_gnt", gnt_o, 4'b0000);
    check("rst_push", fifo_push_o, 1'b0);
    check("rst_flush", fifo_flush_o, 1'b0);
    check("rst_ack", flush_ack_o, 1'b0);
    check("rst_idx", idx_o, 2'd0);
    rst_ni = 1'b1;

    // all four request: grants 0,1,2,3 in order, pointer wraps to 0
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);   // rr=0 -> picks 3 since only 3 requests
    // pointer to 3, then only req 0 -> wrap-around grant 0, rr becomes 1
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);   // expects index 1

    // full stalls three cycles then push of producer 2
    data_i[2] = 32'hC0DE_0002;
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);

    // flush collides with a push request: flush wins, then ACK, then push of 1
    data_i[1] = 32'hF1F1_0001;
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);

    // flush requests held through FLUSH and ACK are not queued
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // reset pulsed while in FLUSH: outputs cleared, no ack after release
    step(4'b0100, 1'b0, 1'b0);   // rr -> 3
    step(4'b0000, 1'b0, 1'b1);   // now in FLUSH
    req_i  = 4'b1111;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_gnt", gnt_o, 4'b0000);
    check("mid_rst_push", fifo_push_o, 1'b0);
    check("mid_rst_flush", fifo_flush_o, 1'b0);
    check("mid_rst_ack", flush_ack_o, 1'b0);
    check("mid_rst_idx", idx_o, 2'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);   // rr reset to 0 -> grant 0

    // random traffic: producers hold req/data until granted
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
          pend[k]   = 1'b1;
          data_i[k] = $urandom;
        end
      end
      step(pend, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      pend = pend & ~last_gnt;
    end

`ifdef FIFO_PUSH_ARB_STATS_EN
    // long stall: counter saturates without wrapping
    for (int i = 0; i < 70000; i++) step(4'b0001, 1'b1, 1'b0);
    check("stall_sat", stall_cnt_o, 16'hFFFF);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of producers, range 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per producer.
REQ-003 SHALL have port clk_i  input  1: single clock.
REQ-004 SHALL have port rst_ni  input  1: asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  NUM_REQ: per-producer push request.
REQ-006 SHALL have port data_i  input  NUM_REQ x DATA_WIDTH: per-producer payload.
REQ-007 SHALL have port gnt_o  output  NUM_REQ: one-hot grant; push accepted when req_i[k] & gnt_o[k].
REQ-008 SHALL have port flush_req_i  input  1: request a downstream FIFO flush.
REQ-009 SHALL have port flush_ack_o  output  1: one-cycle flush completion pulse.
REQ-010 SHALL have port fifo_full_i  input  1: full flag from downstream FIFO.
REQ-011 SHALL have port fifo_push_o  output  1: push strobe to downstream FIFO.
REQ-012 SHALL have port fifo_data_o  output  DATA_WIDTH: payload to downstream FIFO.
REQ-013 SHALL have port fifo_flush_o  output  1: flush strobe to downstream FIFO.
REQ-014 SHALL have port idx_o  output  $clog2(NUM_REQ): index of granted producer, 0 when no grant.

Function
REQ-015 SHALL hold a registered round-robin pointer rr_q (width $clog2(NUM_REQ)) and a 3-state FSM: IDLE, FLUSH, ACK.
REQ-016 In IDLE with fifo_full_i=0, SHALL grant the first requesting index searching rr_q, rr_q+1, ... wrapping modulo NUM_REQ; grant is combinational from req_i, zero latency.
REQ-017 SHALL assert no grant when fifo_full_i=1, when state is not IDLE, or when req_i is all zero.
REQ-018 fifo_push_o SHALL equal OR of (req_i & gnt_o); fifo_data_o SHALL equal data_i[idx_o] (don't-care contents when no push, but driven from index 0).
REQ-019 On each push from index k, rr_q SHALL become (k+1) mod NUM_REQ on the next edge; otherwise rr_q holds.
REQ-020 Wrap-around: with rr_q=NUM_REQ-1 and only req_i[0] set, SHALL grant index 0.
REQ-021 IDLE -> FLUSH when flush_req_i=1; no grant is issued in the cycle flush_req_i is sampled high in IDLE (flush takes precedence over a simultaneous push).
REQ-022 FLUSH: fifo_flush_o=1 for exactly one cycle, rr_q reset to 0, then -> ACK.
REQ-023 ACK: flush_ack_o=1 for exactly one cycle, no grants, then -> IDLE.
REQ-024 flush_req_i in FLUSH or ACK SHALL be ignored (no queued second flush).
REQ-025 Requests stalled by fifo_full_i or flush SHALL remain pending with no loss; producers hold req_i/data_i until granted.

Reset
REQ-026 While rst_ni=0: state=IDLE, rr_q=0, gnt_o=0, fifo_push_o=0, fifo_flush_o=0, flush_ack_o=0, idx_o=0.
REQ-027 Reset asserted mid-flush SHALL abort the flush with no ack pulse after release.

Configuration
REQ-028 Macro FIFO_PUSH_ARB_STATS_EN defined: adds output stall_cnt_o (16 bits), reset 0, incrementing each cycle where |req_i=1 and no grant is issued, saturating at 16'hFFFF, cleared in FLUSH state.
REQ-029 Macro undefined: stall_cnt_o port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 After reset, req_i=4'b1111, fifo_full_i=0 for 4 cycles -> grants 0,1,2,3 in order, 4 pushes, rr_q back to 0.
REQ-031 rr_q=3, req_i=4'b0001 -> gnt_o=4'b0001, idx_o=0 same cycle, rr_q=1 next cycle.
REQ-032 req_i=4'b0100, fifo_full_i=1 for 3 cycles then 0 -> no push for 3 cycles, push of data_i[2] in 4th; with STATS_EN stall_cnt_o=3.
REQ-033 flush_req_i=1 and req_i=4'b0010 same cycle in IDLE -> no push that cycle, fifo_flush_o next cycle, flush_ack_o following cycle, then push of index 1.
REQ-034 rst_ni pulsed low while in FLUSH -> all outputs 0, state IDLE, no flush_ack_o after release.
REQ-035 With STATS_EN, hold fifo_full_i=1 and req_i nonzero for 70000 cycles -> stall_cnt_o=16'hFFFF, no wrap.
